lift5_call_panel: RTL and testbench

Floor call panel sitting on the request side of `lift5`: it turns raw, bouncy hall/car buttons for the five floors A–E into the clean single-cycle request pulses `lift5` consumes on `ra`..`re`. It watches `lift5`'s `floor` output to retire calls once the car has dwelt at a floor. It also drives per-floor call lamps and periodically re-issues unserved calls so a dropped pulse never strands a passenger.

---
 rtl/lift5_call_panel_if.sv | 23 ++
 rtl/lift5_call_panel.sv | 123 ++++++++++++
 tb/tb_lift5_call_panel.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lift5_call_panel_if.sv
// Request-side bus between the call panel and its environment: raw buttons and
// car floor in, request pulses and lamps out.
interface lift5_call_panel_if;
  logic [4:0] btn;
  logic [2:0] floor;
  logic       ra;
  logic       rb;
  logic       rc;
  logic       rd;
  logic       re;
  logic [4:0] lamp;
  logic       busy;

  modport master (
    output btn, floor,
    input  ra, rb, rc, rd, re, lamp, busy
  );

  modport slave (
    input  btn, floor,
    output ra, rb, rc, rd, re, lamp, busy
  );
endinterface

// File: rtl/lift5_call_panel.sv
// Five-floor call panel: debounces buttons into request pulses, retires calls
// once the car has dwelt at a floor, and periodically re-issues pending calls.
module lift5_call_panel #(
  parameter int DEBOUNCE = 4,
  parameter int DWELL    = 2,
  parameter int RETRY    = 64
) (
  input  logic                clk,
  input  logic                rst,
  lift5_call_panel_if.slave   bus
);
  localparam int DB_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);
  localparam int DW_W = $clog2(DWELL + 1);
  localparam int RT_W = $clog2(RETRY);

  logic [4:0] press;

  for (genvar gi = 0; gi < 5; gi++) begin : g_btn
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            deb_q, deb_d;
    logic            deb_prev_q, deb_prev_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    always_comb begin
      sync1_d    = bus.btn[gi];
      sync2_d    = sync1_q;
      deb_prev_d = deb_q;
      deb_d      = deb_q;
      cnt_d      = '0;
      if (sync2_q != deb_q) begin
        if (cnt_q == DB_W'(DEBOUNCE - 1)) begin
          deb_d = sync2_q;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync1_q    <= 1'b0;
        sync2_q    <= 1'b0;
        deb_q      <= 1'b0;
        deb_prev_q <= 1'b0;
        cnt_q      <= '0;
      end else begin
        sync1_q    <= sync1_d;
        sync2_q    <= sync2_d;
        deb_q      <= deb_d;
        deb_prev_q <= deb_prev_d;
        cnt_q      <= cnt_d;
      end
    end

    assign press[gi] = deb_q & ~deb_prev_q;
  end

  logic [2:0]      floor_prev_q, floor_prev_d;
  logic [DW_W-1:0] run_q, run_d;
  logic [RT_W-1:0] rt_q, rt_d;
  logic [4:0]      pend_q, pend_d;
  logic [4:0]      req_q, req_d;
  logic            busy_q, busy_d;
  logic [4:0]      clr;
  logic            new_stay;
  logic            wrap;

  always_comb begin
    floor_prev_d = bus.floor;
    new_stay     = (bus.floor != floor_prev_q);
    // run_d counts edges in the current stay, so the first sample of a stay is 1
    if (new_stay) begin
      run_d = DW_W'(1);
    end else if (run_q == DW_W'(DWELL)) begin
      run_d = run_q;
    end else begin
      run_d = run_q + DW_W'(1);
    end

    clr = '0;
    for (int i = 0; i < 5; i++) begin
      if (bus.floor == 3'(i) && run_d == DW_W'(DWELL) &&
          (new_stay || run_q != DW_W'(DWELL))) begin
        clr[i] = 1'b1;
      end
    end

    wrap = (rt_q == RT_W'(RETRY - 1));
    rt_d = wrap ? '0 : rt_q + RT_W'(1);

    // a press always wins over a same-cycle arrival clear
    pend_d = press | (pend_q & ~clr);
    req_d  = (press & (~pend_q | clr)) | ({5{wrap}} & pend_q);
    busy_d = |pend_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      floor_prev_q <= '0;
      run_q        <= '0;
      rt_q         <= '0;
      pend_q       <= '0;
      req_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      floor_prev_q <= floor_prev_d;
      run_q        <= run_d;
      rt_q         <= rt_d;
      pend_q       <= pend_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.ra   = req_q[0];
  assign bus.rb   = req_q[1];
  assign bus.rc   = req_q[2];
  assign bus.rd   = req_q[3];
  assign bus.re   = req_q[4];
  assign bus.lamp = pend_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_lift5_call_panel.sv
// Bench for lift5_call_panel: directed scenarios plus random traffic, all
// checked cycle by cycle against a history-based reference model.
module tb_lift5_call_panel;
  localparam int DEBOUNCE = 4;
  localparam int DWELL    = 2;
  localparam int RETRY    = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  lift5_call_panel_if bus ();

  lift5_call_panel #(.DEBOUNCE(DEBOUNCE), .DWELL(DWELL), .RETRY(RETRY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: raw histories of button and floor samples
  int unsigned m_edge;
  logic [4:0]  m_bq[$];
  logic [4:0]  m_syncq[$];
  logic [2:0]  m_fq[$];
  logic [4:0]  m_deb, m_rose, m_pend, m_req;
  logic        m_busy;

  task automatic model_reset();
    m_edge = 0;
    m_bq.delete();
    m_syncq.delete();
    m_fq.delete();
    m_deb  = '0;
    m_rose = '0;
    m_pend = '0;
    m_req  = '0;
    m_busy = 1'b0;
  endtask

  task automatic model_edge(input logic [4:0] b, input logic [2:0] f);
    logic [4:0] synced, press, clr;
    logic all_same, fresh, all_diff;
    m_edge++;
    // the debouncer at this edge sees the button as sampled two edges ago
    synced = (m_bq.size() >= 2) ? m_bq[m_bq.size()-2] : 5'b0;
    m_bq.push_back(b);
    if (m_bq.size() > 3) void'(m_bq.pop_front());

    m_fq.push_back(f);
    if (m_fq.size() > DWELL + 1) void'(m_fq.pop_front());
    clr = '0;
    if (f <= 3'd4 && m_fq.size() >= DWELL) begin
      all_same = 1'b1;
      for (int j = 0; j < DWELL; j++)
        if (m_fq[m_fq.size()-1-j] != f) all_same = 1'b0;
      fresh = (m_fq.size() == DWELL) || (m_fq[0] != f);
      if (all_same && fresh) clr[f] = 1'b1;
    end

    press  = m_rose;
    m_req  = (press & (~m_pend | clr)) | (((m_edge % RETRY) == 0) ? m_pend : 5'b0);
    m_pend = press | (m_pend & ~clr);
    m_busy = |m_pend;

    m_syncq.push_back(synced);
    if (m_syncq.size() > DEBOUNCE) void'(m_syncq.pop_front());
    m_rose = '0;
    if (m_syncq.size() == DEBOUNCE) begin
      for (int i = 0; i < 5; i++) begin
        all_diff = 1'b1;
        for (int e = 0; e < DEBOUNCE; e++)
          if (m_syncq[e][i] == m_deb[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_deb[i]  = ~m_deb[i];
          m_rose[i] = m_deb[i];
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else model_edge(bus.btn, bus.floor);
    #1;
  endtask

  task automatic do_reset(input logic [4:0] b, input logic [2:0] f);
    rst = 1'b0;
    bus.btn = b;
    bus.floor = f;
    model_reset();
    repeat (2) tick();
    rst = 1'b1;
  endtask

  function automatic logic [4:0] req_vec();
    return {bus.re, bus.rd, bus.rc, bus.rb, bus.ra};
  endfunction

  task automatic test_reset();
    do_reset(5'b11111, 3'd7);
    rst = 1'b0;
    tick();
    if (req_vec() !== 5'b0 || bus.lamp !== 5'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: req=%b lamp=%b busy=%b, required all zero", req_vec(), bus.lamp, bus.busy);
    end
    tests++;
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (req_vec() !== m_req || bus.lamp !== m_pend || bus.busy !== m_busy) begin
        fails++;
        $display("FAIL reset_release edge %0d: req=%b lamp=%b busy=%b, required req=%b lamp=%b busy=%b",
                 k, req_vec(), bus.lamp, bus.busy, m_req, m_pend, m_busy);
      end
      tests++;
      if (k == 6 && req_vec() !== 5'b0) begin
        fails++;
        $display("FAIL reset_early_pulse: req=%b, required 00000", req_vec());
      end
      if (k == 7 && (req_vec() !== 5'b11111 || bus.lamp !== 5'b11111)) begin
        fails++;
        $display("FAIL reset_press_all: req=%b lamp=%b, required 11111/11111", req_vec(), bus.lamp);
      end
      if (k == 6 || k == 7) tests++;
    end
    $display("[TB] reset scenario done");
  endtask

  task automatic test_clean_press();
    do_reset(5'b0, 3'd0);
    repeat (3) tick();
    bus.btn = 5'b00100;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (req_vec() !== m_req || bus.lamp !== m_pend || bus.busy !== m_busy) begin
        fails++;
        $display("FAIL clean_press edge %0d: req=%b lamp=%b, required req=%b lamp=%b", k, req_vec(), bus.lamp, m_req, m_pend);
      end
      tests++;
      if (k == 7) begin
        if (bus.rc !== 1'b1 || bus.lamp !== 5'b00100) begin
          fails++;
          $display("FAIL clean_press_rc: rc=%b lamp=%b, required 1/00100", bus.rc, bus.lamp);
        end
        tests++;
      end
      if (k == 8) begin
        if (bus.rc !== 1'b0) begin
          fails++;
          $display("FAIL clean_press_width: rc=%b, required 0", bus.rc);
        end
        tests++;
      end
    end
    bus.btn = 5'b0;
    bus.floor = 3'd2;
    repeat (2) tick();
    if (bus.lamp !== 5'b0 || bus.busy !== 1'b0 || m_pend !== 5'b0) begin
      fails++;
      $display("FAIL arrival_clear: lamp=%b busy=%b, required 00000/0", bus.lamp, bus.busy);
    end
    tests++;
    $display("[TB] clean press scenario done");
  endtask

  task automatic test_bounce();
    int pulses = 0;
    do_reset(5'b0, 3'd0);
    for (int c = 0; c < 20 + 10; c++) begin
      bus.btn[1] = (c >= 20) ? 1'b1 : (((c / 2) % 2) == 0);
      tick();
      if (req_vec() !== m_req || bus.lamp !== m_pend) begin
        fails++;
        $display("FAIL bounce cycle %0d: req=%b lamp=%b, required req=%b lamp=%b", c, req_vec(), bus.lamp, m_req, m_pend);
      end
      tests++;
      if (bus.rb === 1'b1) begin
        pulses++;
        if (c != 26) begin
          fails++;
          $display("FAIL bounce_timing: rb high at cycle %0d, required only at 26", c);
        end
        tests++;
      end
    end
    if (pulses != 1) begin
      fails++;
      $display("FAIL bounce_count: %0d rb pulses, required 1", pulses);
    end
    tests++;
    $display("[TB] bounce scenario done");
  endtask

  task automatic test_retry();
    int pulses = 0;
    do_reset(5'b10000, 3'd0);
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (req_vec() !== m_req || bus.lamp !== m_pend || bus.busy !== m_busy) begin
        fails++;
        $display("FAIL retry edge %0d: req=%b lamp=%b, required req=%b lamp=%b", k, req_vec(), bus.lamp, m_req, m_pend);
      end
      tests++;
      if (bus.re === 1'b1) pulses++;
      if (k >= 7 && bus.lamp[4] !== 1'b1) begin
        fails++;
        $display("FAIL retry_lamp edge %0d: lamp[4]=%b, required 1", k, bus.lamp[4]);
      end
      if (k >= 7) tests++;
    end
    if (pulses != 4) begin
      fails++;
      $display("FAIL retry_count: %0d re pulses, required 4", pulses);
    end
    tests++;
    $display("[TB] retry scenario done");
  endtask

  task automatic test_collisions();
    int rb_n = 0;
    int rd_n = 0;
    do_reset(5'b01010, 3'd0);
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (req_vec() !== m_req || bus.lamp !== m_pend || bus.busy !== m_busy) begin
        fails++;
        $display("FAIL collision edge %0d: req=%b lamp=%b, required req=%b lamp=%b", k, req_vec(), bus.lamp, m_req, m_pend);
      end
      tests++;
      if (bus.rb === 1'b1) rb_n++;
      if (bus.rd === 1'b1) rd_n++;
      if (k == 22) begin
        if (bus.rb !== 1'b1 || bus.lamp[1] !== 1'b1) begin
          fails++;
          $display("FAIL press_vs_clear: rb=%b lamp[1]=%b, required 1/1", bus.rb, bus.lamp[1]);
        end
        tests++;
      end
      if (k == 8)  bus.btn = 5'b0;
      if (k == 15) bus.btn = 5'b01010;
      if (k == 20) bus.floor = 3'd1;
    end
    if (rd_n != 1 || rb_n != 2 || bus.lamp[1] !== 1'b1 || bus.lamp[3] !== 1'b1) begin
      fails++;
      $display("FAIL collision_counts: rd=%0d rb=%0d lamp=%b, required rd=1 rb=2 lamp[3:1] 1x1",
               rd_n, rb_n, bus.lamp);
    end
    tests++;
    $display("[TB] collision scenario done");
  endtask

  task automatic test_floor_filter();
    do_reset(5'b11111, 3'd7);
    repeat (7) tick();
    bus.btn = 5'b0;
    for (int k = 0; k < 14; k++) begin
      bus.floor = (k == 10) ? 3'd3 : 3'd7;
      tick();
      if (bus.lamp !== 5'b11111 || bus.lamp !== m_pend || req_vec() !== m_req) begin
        fails++;
        $display("FAIL floor_filter cycle %0d: lamp=%b req=%b, required lamp=11111 req=%b", k, bus.lamp, req_vec(), m_req);
      end
      tests++;
    end
    $display("[TB] floor filter scenario done");
  endtask

  task automatic test_random();
    int idx;
    do_reset(5'b0, 3'd0);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, 4);
        bus.btn[idx] = ~bus.btn[idx];
      end
      if ($urandom_range(0, 4) == 0) bus.floor = 3'($urandom_range(0, 7));
      if (c == 2000) begin
        rst = 1'b0;
        model_reset();
      end
      if (c == 2003) rst = 1'b1;
      tick();
      if (req_vec() !== m_req || bus.lamp !== m_pend || bus.busy !== m_busy) begin
        fails++;
        $display("FAIL random cycle %0d: req=%b lamp=%b busy=%b, required req=%b lamp=%b busy=%b",
                 c, req_vec(), bus.lamp, bus.busy, m_req, m_pend, m_busy);
      end
      tests++;
    end
    $display("[TB] random scenario done");
  endtask

  initial begin
    bus.btn = 5'b0;
    bus.floor = 3'd0;
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_retry();
    test_collisions();
    test_floor_filter();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
